cpu_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction decoder.
- Owns the program counter, the instruction register (IR) and the one-bit execute-phase register.
- Fetches 16-bit instructions over a valid/ready-style instruction-memory handshake and presents IR and State to the decoder.
- Consumes the decoder's PS, IR_L and NS to sequence single- and two-cycle instructions and to update the PC.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/cpu_pc_next.sv | 32 +++
 rtl/cpu_fetch_unit.sv | 102 ++++++++++
 tb/tb_cpu_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU fetch path: PC-select encodings, fetch FSM
// states and the default reset address.
package cpu_pkg;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REL  = 2'b10;
    localparam logic [1:0] PS_ABS  = 2'b11;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        WAIT  = 2'b01,
        EXEC  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/cpu_pc_next.sv
// Next-PC selection: hold, increment, PC-relative branch or absolute target.
// All arithmetic is 16-bit and wraps.
module cpu_pc_next
    import cpu_pkg::*;
#(
    parameter int OFF_W = 8
) (
    input  logic [15:0]      pc,
    input  logic [1:0]       ps,
    input  logic [OFF_W-1:0] off,
    input  logic [15:0]      pc_target,
    output logic [15:0]      next_pc
);

    logic [15:0] off_sext;
    logic [15:0] pc_inc;

    assign off_sext = 16'($signed(off));
    assign pc_inc   = pc + 16'd1;

    always_comb begin
        next_pc = pc;
        case (ps)
            PS_HOLD: next_pc = pc;
            PS_INC:  next_pc = pc_inc;
            PS_REL:  next_pc = pc_inc + off_sext;
            PS_ABS:  next_pc = pc_target;
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: owns PC, IR and the execute-phase bit, fetches over
// a req/valid memory handshake and sequences one- and two-phase instructions.
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          OFF_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic [1:0]  ps,
    input  logic        ir_l,
    input  logic        ns,
    input  logic [15:0] pc_target,
    input  logic        stall,
    output logic [15:0] ir,
    output logic        state,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic        ex_valid,
    output logic [1:0]  dbg_fsm
);

    // Memory handshake: imem_req is high for exactly the FETCH cycle and
    // imem_addr carries the PC; the returned word is taken in the first WAIT
    // cycle with imem_valid=1, and imem_valid is ignored in any other state.

    fetch_state_e fsm_q, fsm_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  ir_q, ir_d;
    logic         state_q, state_d;
    logic [15:0]  next_pc;

    cpu_pc_next #(
        .OFF_W (OFF_W)
    ) u_pc_next (
        .pc        (pc_q),
        .ps        (ps),
        .off       (ir_q[OFF_W-1:0]),
        .pc_target (pc_target),
        .next_pc   (next_pc)
    );

    always_comb begin
        fsm_d   = fsm_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        state_d = state_q;
        case (fsm_q)
            FETCH: fsm_d = WAIT;
            WAIT: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = 1'b0;
                    fsm_d   = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_d = next_pc;
                    // ns wins over ir_l: a second phase always runs first.
                    if (ns) begin
                        state_d = 1'b1;
                    end else begin
                        state_d = 1'b0;
                        if (ir_l) fsm_d = FETCH;
                    end
                end
            end
            default: fsm_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            state_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            state_q <= state_d;
        end
    end

    // Gated by rst so nothing is requested or executed during a reset cycle.
    assign imem_req  = (fsm_q == FETCH) && !rst;
    assign ex_valid  = (fsm_q == EXEC) && !stall && !rst;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc_plus1  = pc_q + 16'd1;
    assign ir        = ir_q;
    assign state     = state_q;
    assign dbg_fsm   = fsm_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_cpu_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [1:0]  ps;
    logic        ir_l;
    logic        ns;
    logic [15:0] pc_target;
    logic        stall;
    logic [15:0] ir;
    logic        state;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        ex_valid;
    logic [1:0]  dbg_fsm;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    cpu_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .ps         (ps),
        .ir_l       (ir_l),
        .ns         (ns),
        .pc_target  (pc_target),
        .stall      (stall),
        .ir         (ir),
        .state      (state),
        .pc         (pc),
        .pc_plus1   (pc_plus1),
        .ex_valid   (ex_valid),
        .dbg_fsm    (dbg_fsm)
    );

    // Clock / reset block.
    always #5 clk = ~clk;

    // Behavioural model: the unit is in one of three activities
    // (requesting, awaiting data, executing) and tracks PC, IR and phase.
    localparam int M_REQ = 0;
    localparam int M_AWAIT = 1;
    localparam int M_RUN = 2;

    int          m_act   = M_REQ;
    logic [15:0] m_pc    = 16'h0000;
    logic [15:0] m_ir    = 16'h0000;
    logic        m_phase = 1'b0;

    function automatic logic [15:0] m_next(input logic [15:0] cur, input logic [1:0] sel,
                                           input logic [15:0] word, input logic [15:0] tgt);
        int off;
        int sum;
        off = int'(word[7:0]);
        if (off > 127) off = off - 256;
        case (sel)
            2'd0:    sum = int'(cur);
            2'd1:    sum = int'(cur) + 1;
            2'd2:    sum = int'(cur) + 1 + off;
            default: sum = int'(tgt);
        endcase
        return 16'(sum & 32'hFFFF);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act   = M_REQ;
            m_pc    = 16'h0000;
            m_ir    = 16'h0000;
            m_phase = 1'b0;
        end else begin
            case (m_act)
                M_REQ: m_act = M_AWAIT;
                M_AWAIT: if (imem_valid) begin
                    m_ir    = imem_rdata;
                    m_phase = 1'b0;
                    m_act   = M_RUN;
                end
                default: if (!stall) begin
                    m_pc = m_next(m_pc, ps, m_ir, pc_target);
                    if (ns) m_phase = 1'b1;
                    else begin
                        m_phase = 1'b0;
                        if (ir_l) m_act = M_REQ;
                    end
                end
            endcase
        end
        check_en = 1'b1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("imem_req", 16'(imem_req), 16'(!rst && m_act == M_REQ));
            check("imem_addr", imem_addr, m_pc);
            check("pc", pc, m_pc);
            check("pc_plus1", pc_plus1, 16'((int'(m_pc) + 1) & 32'hFFFF));
            check("ir", ir, m_ir);
            check("state", 16'(state), 16'(m_phase));
            check("ex_valid", 16'(ex_valid), 16'(!rst && m_act == M_RUN && !stall));
        end
    end

    // Driver tasks.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Called in the middle of a request cycle; ends in the middle of the next one.
    task automatic run_instr(input logic [15:0] word, input logic [1:0] sel, input logic [15:0] tgt);
        cyc();
        imem_valid = 1'b1;
        imem_rdata = word;
        cyc();
        imem_valid = 1'b0;
        ps = sel;
        pc_target = tgt;
        ns = 1'b0;
        ir_l = 1'b1;
        stall = 1'b0;
        cyc();
        mid();
    endtask

    initial begin
        rst = 1'b1;
        imem_rdata = 16'h0000;
        imem_valid = 1'b0;
        ps = 2'b00;
        ir_l = 1'b0;
        ns = 1'b0;
        pc_target = 16'h0000;
        stall = 1'b0;

        // Pin the model's PC arithmetic.
        check("model_rel", m_next(16'h0010, 2'd2, 16'h00F0, 16'h0000), 16'h0001);
        check("model_wrap", m_next(16'hFFFF, 2'd1, 16'h0000, 16'h0000), 16'h0000);
        check("model_back1", m_next(16'h0100, 2'd2, 16'h00FE, 16'h0000), 16'h00FF);

        cyc();
        cyc();
        rst = 1'b0;

        // First fetch, zero-wait memory.
        mid();
        check("t1_req", 16'(imem_req), 16'h0001);
        check("t1_addr", imem_addr, 16'h0000);
        cyc();
        imem_valid = 1'b1;
        imem_rdata = 16'h1234;
        mid();
        check("t1_wait_req", 16'(imem_req), 16'h0000);
        cyc();
        imem_valid = 1'b0;
        ps = 2'b01;
        ir_l = 1'b1;
        ns = 1'b0;
        mid();
        check("t1_ir", ir, 16'h1234);
        check("t1_state", 16'(state), 16'h0000);
        check("t1_exv", 16'(ex_valid), 16'h0001);
        cyc();
        mid();
        check("t1_req2", 16'(imem_req), 16'h0001);
        check("t1_addr2", imem_addr, 16'h0001);

        // Slow memory: three WAIT cycles without valid.
        cyc();
        ps = 2'b00;
        ir_l = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("t2_req", 16'(imem_req), 16'h0000);
            check("t2_ir", ir, 16'h1234);
            check("t2_exv", 16'(ex_valid), 16'h0000);
            cyc();
        end
        imem_valid = 1'b1;
        imem_rdata = 16'h0100;
        mid();
        check("t2_ir_hold", ir, 16'h1234);

        // Two-phase instruction ending in an absolute jump.
        cyc();
        imem_valid = 1'b0;
        ns = 1'b1;
        ps = 2'b00;
        ir_l = 1'b0;
        mid();
        check("t3_ex0_state", 16'(state), 16'h0000);
        check("t3_ex0_ir", ir, 16'h0100);
        check("t3_ex0_pc", pc, 16'h0001);
        cyc();
        ns = 1'b0;
        ir_l = 1'b1;
        ps = 2'b11;
        pc_target = 16'h0040;
        mid();
        check("t3_ex1_state", 16'(state), 16'h0001);
        check("t3_ex1_ir", ir, 16'h0100);
        check("t3_ex1_pc", pc, 16'h0001);
        cyc();
        mid();
        check("t3_addr", imem_addr, 16'h0040);
        check("t3_req", 16'(imem_req), 16'h0001);

        // Relative branch backwards and PC wrap.
        run_instr(16'h0000, 2'b11, 16'h0010);
        check("t4_addr_10", imem_addr, 16'h0010);
        run_instr(16'h12F0, 2'b10, 16'h0000);
        check("t4_rel", imem_addr, 16'h0001);
        run_instr(16'h0000, 2'b11, 16'hFFFF);
        check("t4_addr_ffff", imem_addr, 16'hFFFF);
        check("t4_plus1_wrap", pc_plus1, 16'h0000);
        run_instr(16'h0000, 2'b01, 16'h0000);
        check("t4_wrap", imem_addr, 16'h0000);

        // Stall in WAIT is ignored; stall in EXEC freezes everything.
        cyc();
        imem_valid = 1'b1;
        imem_rdata = 16'h5A5A;
        stall = 1'b1;
        cyc();
        imem_valid = 1'b0;
        ps = 2'b01;
        ns = 1'b0;
        ir_l = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mid();
            check("t5_exv", 16'(ex_valid), 16'h0000);
            check("t5_pc", pc, 16'h0000);
            check("t5_ir", ir, 16'h5A5A);
            check("t5_state", 16'(state), 16'h0000);
            cyc();
        end
        stall = 1'b0;
        mid();
        check("t5_exv_resume", 16'(ex_valid), 16'h0001);
        cyc();
        mid();
        check("t5_addr", imem_addr, 16'h0001);

        // Reset during WAIT, stale valid in the following FETCH.
        cyc();
        imem_valid = 1'b0;
        rst = 1'b1;
        mid();
        check("t6_rst_req", 16'(imem_req), 16'h0000);
        check("t6_rst_exv", 16'(ex_valid), 16'h0000);
        cyc();
        rst = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 16'hDEAD;
        mid();
        check("t6_req", 16'(imem_req), 16'h0001);
        check("t6_addr", imem_addr, 16'h0000);
        check("t6_ir", ir, 16'h0000);
        cyc();
        imem_valid = 1'b0;
        mid();
        check("t6_ir_stale", ir, 16'h0000);
        check("t6_wait_req", 16'(imem_req), 16'h0000);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc();
            rst        = ($urandom_range(0, 249) == 0);
            imem_valid = ($urandom_range(0, 2) == 0);
            imem_rdata = 16'($urandom);
            ps         = 2'($urandom_range(0, 3));
            ns         = ($urandom_range(0, 3) == 0);
            ir_l       = ($urandom_range(0, 4) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            pc_target  = 16'($urandom);
        end
        cyc();
        rst = 1'b0;
        stall = 1'b0;
        mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
